// File: rtl/ex_stage.sv
// Execute stage: operand bypass, ALU, branch resolution and a single-entry
// registered EX/MEM slot with combinational backpressure.

module alu (
    input  logic [3:0]  alu_code_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    output logic [31:0] result_o
);
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_CMP  = 4'd10;
    localparam logic [3:0] ALU_CMPU = 4'd11;
    localparam logic [3:0] ALU_PASS = 4'd12;

    logic [4:0] shamt;
    logic       eq;
    logic       lt_s;
    logic       lt_u;

    assign shamt = op2_i[4:0];
    assign eq    = (op1_i == op2_i);
    assign lt_s  = ($signed(op1_i) < $signed(op2_i));
    assign lt_u  = (op1_i < op2_i);

    // Compare codes report {lt, eq} in bits [1:0] for branch resolution
    always_comb begin
        result_o = 32'd0;
        case (alu_code_i)
            ALU_ADD:  result_o = op1_i + op2_i;
            ALU_SUB:  result_o = op1_i - op2_i;
            ALU_AND:  result_o = op1_i & op2_i;
            ALU_OR:   result_o = op1_i | op2_i;
            ALU_XOR:  result_o = op1_i ^ op2_i;
            ALU_SLL:  result_o = op1_i << shamt;
            ALU_SRL:  result_o = op1_i >> shamt;
            ALU_SRA:  result_o = 32'($signed(op1_i) >>> shamt);
            ALU_SLT:  result_o = {31'd0, lt_s};
            ALU_SLTU: result_o = {31'd0, lt_u};
            ALU_CMP:  result_o = {30'd0, lt_s, eq};
            ALU_CMPU: result_o = {30'd0, lt_u, eq};
            ALU_PASS: result_o = op2_i;
            default:  result_o = 32'd0;
        endcase
    end
endmodule

module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [3:0]  in_alu_code,
    input  logic        in_op1_sel,
    input  logic        in_op2_sel,
    input  logic [2:0]  in_br_type,
    input  logic        in_wb_en,
    input  logic        fwd_en,
    input  logic [4:0]  fwd_rd,
    input  logic [31:0] fwd_val,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        br_taken,
    output logic [31:0] br_target
);
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLT  = 3'd3;
    localparam logic [2:0] BR_BGE  = 3'd4;
    localparam logic [2:0] BR_BLTU = 3'd5;
    localparam logic [2:0] BR_BGEU = 3'd6;
    localparam logic [2:0] BR_JUMP = 3'd7;

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_res_q,   out_res_d;
    logic [4:0]  out_rd_q,    out_rd_d;
    logic        out_wb_en_q, out_wb_en_d;
    logic        br_taken_q,  br_taken_d;
    logic [31:0] br_target_q, br_target_d;

    logic [31:0] rs1_byp, rs2_byp, op1, op2, alu_res;
    logic [31:0] br_add, pc_plus4;
    logic        accept, taken;

    // Bypass priority: x0, then the EX/MEM slot (pre-edge), then writeback
    always_comb begin
        rs1_byp = in_rs1_val;
        if (in_rs1 == 5'd0)
            rs1_byp = in_rs1_val;
        else if (out_valid_q && out_wb_en_q && (out_rd_q == in_rs1))
            rs1_byp = out_res_q;
        else if (fwd_en && (fwd_rd == in_rs1))
            rs1_byp = fwd_val;
    end

    always_comb begin
        rs2_byp = in_rs2_val;
        if (in_rs2 == 5'd0)
            rs2_byp = in_rs2_val;
        else if (out_valid_q && out_wb_en_q && (out_rd_q == in_rs2))
            rs2_byp = out_res_q;
        else if (fwd_en && (fwd_rd == in_rs2))
            rs2_byp = fwd_val;
    end

    assign op1 = in_op1_sel ? in_pc  : rs1_byp;
    assign op2 = in_op2_sel ? in_imm : rs2_byp;

    alu u_alu (
        .alu_code_i (in_alu_code),
        .op1_i      (op1),
        .op2_i      (op2),
        .result_o   (alu_res)
    );

    assign br_add   = in_pc + in_imm;
    assign pc_plus4 = in_pc + 32'd4;

    always_comb begin
        taken = 1'b0;
        case (in_br_type)
            BR_NONE: taken = 1'b0;
            BR_BEQ:  taken = alu_res[0];
            BR_BNE:  taken = !alu_res[0];
            BR_BLT:  taken = alu_res[1];
            BR_BGE:  taken = !alu_res[1];
            BR_BLTU: taken = alu_res[1];
            BR_BGEU: taken = !alu_res[1];
            BR_JUMP: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    // Slot and redirect next-state
    always_comb begin
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_rd_d    = out_rd_q;
        out_wb_en_d = out_wb_en_q;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_rd_d    = in_rd;
            out_res_d   = (in_br_type == BR_JUMP) ? pc_plus4 : alu_res;
            out_wb_en_d = (in_br_type == BR_NONE || in_br_type == BR_JUMP) ? in_wb_en : 1'b0;
            br_taken_d  = taken;
            if (taken)
                br_target_d = (in_br_type == BR_JUMP) ? {alu_res[31:1], 1'b0} : br_add;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_res_q   <= 32'd0;
            out_rd_q    <= 5'd0;
            out_wb_en_q <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= 32'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_rd_q    <= out_rd_d;
            out_wb_en_q <= out_wb_en_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = out_res_q;
    assign out_rd    = out_rd_q;
    assign out_wb_en = out_wb_en_q;
    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expectations.

module tb_ex_stage;
    localparam logic [3:0] A_ADD  = 4'd0;
    localparam logic [3:0] A_SUB  = 4'd1;
    localparam logic [3:0] A_CMP  = 4'd10;
    localparam logic [3:0] A_CMPU = 4'd11;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [3:0]  in_alu_code;
    logic        in_op1_sel, in_op2_sel;
    logic [2:0]  in_br_type;
    logic        in_wb_en;
    logic        fwd_en;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_val;
    logic        flush;
    logic        out_valid, out_ready;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        br_taken;
    logic [31:0] br_target;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_code(in_alu_code), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
        .in_br_type(in_br_type), .in_wb_en(in_wb_en),
        .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_val(fwd_val),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_rd(out_rd), .out_wb_en(out_wb_en),
        .br_taken(br_taken), .br_target(br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] v1,
                         input logic [4:0] rs2, input logic [31:0] v2, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [3:0] code, input logic s1,
                         input logic s2, input logic [2:0] br, input logic wb);
        in_valid = 1'b1; in_pc = pc; in_rs1 = rs1; in_rs1_val = v1; in_rs2 = rs2;
        in_rs2_val = v2; in_imm = imm; in_rd = rd; in_alu_code = code;
        in_op1_sel = s1; in_op2_sel = s2; in_br_type = br; in_wb_en = wb;
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1; flush = 1'b0;
        fwd_en = 1'b0; fwd_rd = 5'd0; fwd_val = 32'd0;
        instr(32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, A_ADD, 1'b0, 1'b0, 3'd0, 1'b0);
        in_valid = 1'b0;
        step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_wb", 32'(out_wb_en), 32'd0);
        chk("rst_br", 32'(br_taken), 32'd0);
        chk("rst_res", out_res, 32'd0);
        chk("rst_rd", 32'(out_rd), 32'd0);
        chk("rst_tgt", br_target, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(in_ready), 32'd1);

        // ADD x3 = x1 + x2, then SUB x4 = x3 - x1 via slot bypass
        instr(32'h10, 5'd1, 32'd5, 5'd2, 32'd7, 32'd0, 5'd3, A_ADD, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("add_res", out_res, 32'd12);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_rd", 32'(out_rd), 32'd3);
        instr(32'h14, 5'd3, 32'd0, 5'd1, 32'd5, 32'd0, 5'd4, A_SUB, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("sub_res", out_res, 32'd7);
        chk("sub_valid", 32'(out_valid), 32'd1);

        // Writeback bypass, then slot-over-writeback priority
        fwd_en = 1'b1; fwd_rd = 5'd5; fwd_val = 32'd100;
        instr(32'h18, 5'd5, 32'd1, 5'd2, 32'd7, 32'd0, 5'd6, A_ADD, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("fwd_res", out_res, 32'd107);
        fwd_rd = 5'd6; fwd_val = 32'd999;
        instr(32'h1c, 5'd6, 32'd0, 5'd0, 32'd0, 32'd1, 5'd7, A_ADD, 1'b0, 1'b1, 3'd0, 1'b1);
        step();
        chk("prio_res", out_res, 32'd108);

        // x0 never bypassed
        fwd_rd = 5'd0; fwd_val = 32'h55;
        instr(32'h20, 5'd0, 32'h11, 5'd0, 32'd0, 32'd0, 5'd8, A_ADD, 1'b0, 1'b1, 3'd0, 1'b1);
        step();
        chk("x0_res", out_res, 32'h11);
        fwd_en = 1'b0;

        // BLT taken (signed), then BLTU not taken
        instr(32'h100, 5'd9, 32'hFFFF_FFFF, 5'd10, 32'd1, 32'h20, 5'd0, A_CMP, 1'b0, 1'b0, 3'd3, 1'b1);
        step();
        chk("blt_taken", 32'(br_taken), 32'd1);
        chk("blt_tgt", br_target, 32'h120);
        chk("blt_wb", 32'(out_wb_en), 32'd0);
        chk("blt_res", out_res, 32'd2);
        instr(32'h100, 5'd9, 32'hFFFF_FFFF, 5'd10, 32'd1, 32'h20, 5'd0, A_CMPU, 1'b0, 1'b0, 3'd5, 1'b1);
        step();
        chk("bltu_taken", 32'(br_taken), 32'd0);
        chk("bltu_tgt_hold", br_target, 32'h120);
        chk("bltu_res", out_res, 32'd0);

        // BGE on equal operands is taken
        instr(32'h200, 5'd9, 32'd5, 5'd10, 32'd5, 32'h10, 5'd0, A_CMP, 1'b0, 1'b0, 3'd4, 1'b0);
        step();
        chk("bge_taken", 32'(br_taken), 32'd1);
        chk("bge_tgt", br_target, 32'h210);

        // JALR rd=1, rs1=0x1001, imm=4
        instr(32'h40, 5'd11, 32'h1001, 5'd0, 32'd0, 32'd4, 5'd1, A_ADD, 1'b0, 1'b1, 3'd7, 1'b1);
        step();
        chk("jalr_res", out_res, 32'h44);
        chk("jalr_tgt", br_target, 32'h1004);
        chk("jalr_taken", 32'(br_taken), 32'd1);
        chk("jalr_wb", 32'(out_wb_en), 32'd1);
        in_valid = 1'b0;
        step();
        chk("jalr_one_cycle", 32'(br_taken), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);

        // Backpressure: slot full, out_ready low for 3 cycles
        instr(32'h50, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 5'd12, A_ADD, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        chk("fill_res", out_res, 32'd7);
        out_ready = 1'b0;
        instr(32'h54, 5'd14, 32'd10, 5'd15, 32'd20, 32'd0, 5'd13, A_ADD, 1'b0, 1'b0, 3'd0, 1'b1);
        #1;
        chk("stall_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_res", out_res, 32'd7);
            chk("stall_rd", 32'(out_rd), 32'd12);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_ready_hold", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("release_res", out_res, 32'd30);
        chk("release_rd", 32'(out_rd), 32'd13);
        chk("release_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("no_dup_valid", 32'(out_valid), 32'd0);

        // Flush wins over accept
        flush = 1'b1;
        instr(32'h60, 5'd0, 32'd0, 5'd0, 32'd0, 32'd8, 5'd1, A_ADD, 1'b1, 1'b1, 3'd7, 1'b1);
        step();
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_br", 32'(br_taken), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;

        // Reset mid-stall drops held instruction and overrides accept
        instr(32'h70, 5'd1, 32'd1, 5'd2, 32'd1, 32'd0, 5'd5, A_ADD, 1'b0, 1'b0, 3'd0, 1'b1);
        step();
        out_ready = 1'b0;
        instr(32'h74, 5'd0, 32'd0, 5'd0, 32'd0, 32'd8, 5'd1, A_ADD, 1'b1, 1'b1, 3'd7, 1'b1);
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_stall_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_br", 32'(br_taken), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rst_stall_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // JAL at top of address space: link wraps to zero
        instr(32'hFFFF_FFFC, 5'd0, 32'd0, 5'd0, 32'd0, 32'd8, 5'd1, A_ADD, 1'b1, 1'b1, 3'd7, 1'b1);
        step();
        chk("wrap_res", out_res, 32'h0000_0000);
        chk("wrap_tgt", br_target, 32'h0000_0004);
        chk("wrap_taken", 32'(br_taken), 32'd1);
        in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The module SHALL have a single clock and a synchronous, active-high reset; all state updates on the rising edge of clk.
REQ-002 clk  in  1  clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 in_valid  in  1  decoded instruction present; in_ready  out  1  stage can accept it.
REQ-005 in_pc, in_rs1_val, in_rs2_val, in_imm  in  32 each  PC, register-file operands, sign-extended immediate.
REQ-006 in_rs1, in_rs2, in_rd  in  5 each  source/destination register indices.
REQ-007 in_alu_code  in  4  ALU operation (codebase ALU code set); in_op1_sel  in  1  (0 rs1, 1 pc); in_op2_sel  in  1  (0 rs2, 1 imm).
REQ-008 in_br_type  in  3  0 none, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 BLTU, 6 BGEU, 7 JUMP; in_wb_en  in  1  result writes rd.
REQ-009 fwd_en  in  1, fwd_rd  in  5, fwd_val  in  32  writeback-stage bypass.
REQ-010 flush  in  1  discard the instruction offered this cycle.
REQ-011 out_valid  out  1, out_ready  in  1, out_res  out  32, out_rd  out  5, out_wb_en  out  1  registered EX/MEM slot.
REQ-012 br_taken  out  1, br_target  out  32  registered redirect to fetch.

Function
REQ-013 The module SHALL instantiate the codebase alu with alu_code = in_alu_code and op1/op2 from the operand muxes below.
REQ-014 Operand bypass per source (rs1, rs2), priority: index 0 -> register value; out_valid & out_wb_en & out_rd==idx -> out_res; fwd_en & fwd_rd==idx -> fwd_val; else in_rsX_val.
REQ-015 op1 = in_op1_sel ? in_pc : bypassed rs1; op2 = in_op2_sel ? in_imm : bypassed rs2.
REQ-016 in_ready SHALL equal !out_valid | out_ready (single-entry slot, combinational backpressure).
REQ-017 Accept = in_valid & in_ready & !flush; on accept the output slot SHALL load next cycle (1-cycle latency).
REQ-018 Without accept: out_ready=1 clears out_valid; out_ready=0 holds out_valid and all out_* stable.
REQ-019 Captured values: br_type 0 -> out_res = ALU result, out_wb_en = in_wb_en; br_type 1-6 -> out_wb_en = 0, out_res = ALU result; br_type 7 -> out_res = in_pc + 4, out_wb_en = in_wb_en.
REQ-020 For br_type 1-6 the decoder supplies CMP (BEQ/BNE/BLT/BGE) or CMPU (BLTU/BGEU); ALU bit0 = eq, bit1 = lt.
REQ-021 Taken: BEQ eq; BNE !eq; BLT/BLTU lt; BGE/BGEU !lt; JUMP always.
REQ-022 Target: br_type 1-6 -> in_pc + in_imm via dedicated 32-bit adder; JUMP -> ALU result with bit0 forced to 0 (JAL: pc+imm, JALR: rs1+imm).
REQ-023 br_taken SHALL assert exactly one cycle, the cycle after an accepted taken branch/jump, with br_target valid that cycle; otherwise br_taken = 0, br_target held.
REQ-024 All adders SHALL wrap modulo 2^32 (pc 0xFFFFFFFC + 4 = 0x00000000).
REQ-025 flush and accept-eligibility in the same cycle: flush wins; no capture, no br_taken; existing slot obeys REQ-018.
REQ-026 Accept while out_valid & out_ready: slot replaced by new instruction, out_valid stays 1 (no bubble).
REQ-027 Bypass uses slot contents before the edge, so back-to-back dependent ops forward without stall; load-use hazards are upstream responsibility.

Reset
REQ-028 On rst: out_valid=0, out_wb_en=0, br_taken=0, out_res=0, out_rd=0, br_target=0; rst overrides accept and flush.
REQ-029 rst asserted mid-stall SHALL drop the held instruction; in_ready=1 the cycle after rst deasserts.

Verification
REQ-030 ADD x3=x1+x2 (5, 7), then SUB x4=x3-x1 next cycle -> out_res 12 then 7 via slot bypass, out_valid continuous.
REQ-031 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> br_taken 1 cycle, br_target 0x120, out_wb_en 0; same operands BLTU -> br_taken 0.
REQ-032 JALR rd=1, rs1=0x1001, imm=4, pc=0x40 -> out_res 0x44, br_target 0x1004, br_taken 1 cycle.
REQ-033 out_ready=0 for 3 cycles with slot full -> in_ready 0, out_* stable; release -> next instruction captured, no loss or duplication.
REQ-034 flush with in_valid=1 -> no capture, no br_taken; fwd_en with fwd_rd=0 -> operand reads register value unchanged.
REQ-035 rst during stall -> out_valid 0, br_taken 0 next cycle; pc 0xFFFFFFFC JAL -> out_res 0x00000000.
